idma_desc_queue_nd: RTL

Multi-stream descriptor queue for the register-based iDMA front-end. It accepts launched N-dimensional transfer descriptors on per-stream ports and assigns each one a per-stream transfer ID. Descriptors are buffered in per-stream FIFOs and issued to the single back-end/mid-end request port under round-robin arbitration. Per-stream completion and busy state are tracked for the status registers.

---
 rtl/idma_desc_queue_nd.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/idma_desc_queue_nd.sv
// Multi-stream iDMA descriptor queue: per-stream FIFOs with transfer-ID assignment, round-robin issue
// and completion tracking. Define IDMA_DESC_QUEUE_BYPASS_EN for a same-cycle launch-to-issue bypass.
module idma_desc_queue_nd #(
    parameter int unsigned  NumStreams     = 4,
    parameter int unsigned  Depth          = 4,
    parameter int unsigned  MaxOutstanding = 8,
    parameter int unsigned  IdCounterWidth = 32,
    parameter type          dma_req_t      = logic,
    localparam int unsigned StreamW        = (NumStreams > 1) ? $clog2(NumStreams) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumStreams-1:0]     launch_valid_i,
    output logic [NumStreams-1:0]     launch_ready_o,
    input  dma_req_t                  launch_req_i [NumStreams],
    output logic [IdCounterWidth-1:0] launch_id_o  [NumStreams],
    output logic                      req_valid_o,
    input  logic                      req_ready_i,
    output dma_req_t                  dma_req_o,
    output logic [IdCounterWidth-1:0] req_id_o,
    output logic [StreamW-1:0]        stream_idx_o,
    input  logic                      done_valid_i,
    input  logic [StreamW-1:0]        done_stream_i,
    output logic [IdCounterWidth-1:0] done_id_o    [NumStreams],
    output logic [NumStreams-1:0]     busy_o,
    output logic                      err_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

    typedef logic [IdCounterWidth-1:0] id_t;
    typedef struct packed {
        dma_req_t req;
        id_t      id;
    } entry_t;

    // IDs never take the value 0: all-ones wraps to 1.
    function automatic id_t id_inc(input id_t id);
        return (&id) ? id_t'(1) : id + id_t'(1);
    endfunction

    entry_t             mem_q         [NumStreams][Depth];
    entry_t             mem_d         [NumStreams][Depth];
    logic [PtrW-1:0]    wr_ptr_q      [NumStreams];
    logic [PtrW-1:0]    wr_ptr_d      [NumStreams];
    logic [PtrW-1:0]    rd_ptr_q      [NumStreams];
    logic [PtrW-1:0]    rd_ptr_d      [NumStreams];
    logic [CntW-1:0]    count_q       [NumStreams];
    logic [CntW-1:0]    count_d       [NumStreams];
    id_t                next_id_q     [NumStreams];
    id_t                next_id_d     [NumStreams];
    id_t                done_id_q     [NumStreams];
    id_t                done_id_d     [NumStreams];
    logic [OutW-1:0]    outstanding_q [NumStreams];
    logic [OutW-1:0]    outstanding_d [NumStreams];
    logic [StreamW-1:0] rr_ptr_q, rr_ptr_d;
    logic [StreamW-1:0] lock_stream_q, lock_stream_d;
    logic               lock_q, lock_d;
    logic               err_q, err_d;

    logic [NumStreams-1:0] fifo_empty;
    logic [NumStreams-1:0] fifo_full;
    logic [NumStreams-1:0] launch_accept;
    logic [NumStreams-1:0] cand;
    logic                  grant_valid;
    logic [StreamW-1:0]    grant_idx;
    logic                  bypass_sel;
    logic                  handshake;
    entry_t                out_entry;

    always_comb begin
        for (int s = 0; s < NumStreams; s++) begin
            fifo_empty[s]     = (count_q[s] == '0);
            fifo_full[s]      = (count_q[s] == CntW'(Depth));
            launch_ready_o[s] = !fifo_full[s] && (outstanding_q[s] < OutW'(MaxOutstanding));
            launch_id_o[s]    = next_id_q[s];
            done_id_o[s]      = done_id_q[s];
            busy_o[s]         = !fifo_empty[s] || (outstanding_q[s] != '0);
        end
    end

    assign launch_accept = launch_valid_i & launch_ready_o;
    assign err_o         = err_q;

    // Grant: locked stream while a presented request waits, else first candidate from rr_ptr_q.
    always_comb begin
        int unsigned pos;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        pos         = 0;
        cand        = ~fifo_empty;
`ifdef IDMA_DESC_QUEUE_BYPASS_EN
        cand[rr_ptr_q] = cand[rr_ptr_q] | launch_accept[rr_ptr_q];
`endif
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (lock_q) begin
            grant_valid = 1'b1;
            grant_idx   = lock_stream_q;
        end else begin
            for (int unsigned k = 0; k < NumStreams; k++) begin
                pos = (32'(rr_ptr_q) + k) % NumStreams;
                if (!grant_valid && cand[StreamW'(pos)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = StreamW'(pos);
                end
            end
        end

        out_entry = mem_q[grant_idx][rd_ptr_q[grant_idx]];
`ifdef IDMA_DESC_QUEUE_BYPASS_EN
        bypass_sel = grant_valid && !lock_q && fifo_empty[grant_idx];
        if (bypass_sel) begin
            out_entry.req = launch_req_i[grant_idx];
            out_entry.id  = next_id_q[grant_idx];
        end
`else
        bypass_sel = 1'b0;
`endif
        req_valid_o  = grant_valid && !rst_i;
        dma_req_o    = out_entry.req;
        req_id_o     = out_entry.id;
        stream_idx_o = grant_idx;
        handshake    = req_valid_o && req_ready_i;
    end

    always_comb begin
        logic push, pop, done_hit, done_ok;
        push          = 1'b0;
        pop           = 1'b0;
        done_hit      = 1'b0;
        done_ok       = 1'b0;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        next_id_d     = next_id_q;
        done_id_d     = done_id_q;
        outstanding_d = outstanding_q;
        rr_ptr_d      = rr_ptr_q;
        lock_d        = lock_q;
        lock_stream_d = lock_stream_q;

        for (int s = 0; s < NumStreams; s++) begin
            // A bypassed launch that is taken immediately never enters the FIFO.
            push = launch_accept[s] && !(bypass_sel && (grant_idx == StreamW'(s)) && req_ready_i);
            pop  = handshake && !bypass_sel && (grant_idx == StreamW'(s));
            if (push) begin
                mem_d[s][wr_ptr_q[s]] = '{req: launch_req_i[s], id: next_id_q[s]};
                wr_ptr_d[s]           = wr_ptr_q[s] + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d[s] = rd_ptr_q[s] + PtrW'(1);
            end
            count_d[s] = count_q[s] + CntW'(push) - CntW'(pop);
            if (launch_accept[s]) begin
                next_id_d[s] = id_inc(next_id_q[s]);
            end

            done_hit = done_valid_i && (done_stream_i == StreamW'(s)) && (outstanding_q[s] != '0);
            if (done_hit) begin
                done_id_d[s] = id_inc(done_id_q[s]);
                done_ok      = 1'b1;
            end
            outstanding_d[s] = outstanding_q[s] + OutW'(launch_accept[s]) - OutW'(done_hit);
        end

        // Out-of-range stream or nothing outstanding: the completion is dropped and flagged.
        err_d = done_valid_i && !done_ok;

        if (handshake) begin
            rr_ptr_d = (32'(grant_idx) == NumStreams - 1) ? '0 : grant_idx + StreamW'(1);
            lock_d   = 1'b0;
        end else if (req_valid_o) begin
            lock_d        = 1'b1;
            lock_stream_d = grant_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            for (int s = 0; s < NumStreams; s++) begin
                wr_ptr_q[s]      <= '0;
                rd_ptr_q[s]      <= '0;
                count_q[s]       <= '0;
                next_id_q[s]     <= id_t'(1);
                done_id_q[s]     <= '0;
                outstanding_q[s] <= '0;
            end
            rr_ptr_q      <= '0;
            lock_q        <= 1'b0;
            lock_stream_q <= '0;
            err_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            next_id_q     <= next_id_d;
            done_id_q     <= done_id_d;
            outstanding_q <= outstanding_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_q        <= lock_d;
            lock_stream_q <= lock_stream_d;
            err_q         <= err_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule
